z3_autoconfig: RTL and testbench

Z3_AUTOCONFIG -- requirements
Module: z3_autoconfig

---
 rtl/z3_autoconfig_pkg.sv | 37 +++
 rtl/z3_cfg_rom.sv | 59 +++++
 rtl/z3_autoconfig.sv | 172 +++++++++++++++++
 tb/tb_z3_autoconfig.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z3_autoconfig_pkg.sv
// Shared definitions for the Zorro III autoconfig slice: handshake state
// encoding, config-space register byte offsets and fixed register values.
package z3_autoconfig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_END = 2'd2
    } z3_state_e;

    // Byte offsets of the config-space registers ({ADDR[6:2], 2'b00})
    localparam logic [6:0] REG_ER_TYPE   = 7'h00;
    localparam logic [6:0] REG_PRODUCT   = 7'h04;
    localparam logic [6:0] REG_ER_FLAGS  = 7'h08;
    localparam logic [6:0] REG_MANUF_HI  = 7'h10;
    localparam logic [6:0] REG_MANUF_LO  = 7'h14;
    localparam logic [6:0] REG_SERIAL_3  = 7'h18;
    localparam logic [6:0] REG_SERIAL_2  = 7'h1C;
    localparam logic [6:0] REG_SERIAL_1  = 7'h20;
    localparam logic [6:0] REG_SERIAL_0  = 7'h24;
    localparam logic [6:0] REG_DIAG_HI   = 7'h28;
    localparam logic [6:0] REG_DIAG_LO   = 7'h2C;
    localparam logic [6:0] REG_BASE_ADDR = 7'h44;
    localparam logic [6:0] REG_SHUTUP    = 7'h4C;

    // Fixed register contents (true, uninverted values)
    localparam logic [7:0]  ER_TYPE_PLAIN    = 8'h80;
    localparam logic [7:0]  ER_TYPE_AUTOBOOT = 8'h90;
    localparam logic [7:0]  ER_FLAGS_VAL     = 8'h30;
    localparam logic [15:0] DIAG_VEC         = 16'h0200;

    // Select the low (lo=1) or high (lo=0) nibble of a register byte
    function automatic logic [3:0] pick_nibble(input logic [7:0] b, input logic lo);
        return lo ? b[3:0] : b[7:4];
    endfunction

endpackage

// File: rtl/z3_cfg_rom.sv
// Combinational config-space lookup: 6-bit nibble offset to the nibble
// presented on the bus. Every register except er_Type reads back inverted.
// Build option: define Z3_AUTOBOOT_EN to advertise a ROM vector (er_Type
// 0x90) and expose the diag vector at offsets 0x28/0x2C.
module z3_cfg_rom
    import z3_autoconfig_pkg::*;
#(
    parameter logic [15:0] MANUF_ID   = 16'h0202,
    parameter logic [7:0]  PRODUCT_ID = 8'h54,
    parameter logic [31:0] SERIAL     = 32'h0000_0000
) (
    input  logic [5:0] offset,
    output logic [3:0] nibble
);

`ifdef Z3_AUTOBOOT_EN
    localparam logic [7:0] ER_TYPE_VAL = ER_TYPE_AUTOBOOT;
`else
    localparam logic [7:0] ER_TYPE_VAL = ER_TYPE_PLAIN;
`endif

    logic [6:0] byte_off_s;
    logic [7:0] reg_byte_s;
    logic [3:0] raw_s;

    assign byte_off_s = {offset[4:0], 2'b00};
    assign raw_s      = pick_nibble(reg_byte_s, offset[5]);

    // Register byte lookup by byte offset; unlisted offsets read as zero
    always_comb begin
        reg_byte_s = 8'h00;
        case (byte_off_s)
            REG_ER_TYPE:  reg_byte_s = ER_TYPE_VAL;
            REG_PRODUCT:  reg_byte_s = PRODUCT_ID;
            REG_ER_FLAGS: reg_byte_s = ER_FLAGS_VAL;
            REG_MANUF_HI: reg_byte_s = MANUF_ID[15:8];
            REG_MANUF_LO: reg_byte_s = MANUF_ID[7:0];
            REG_SERIAL_3: reg_byte_s = SERIAL[31:24];
            REG_SERIAL_2: reg_byte_s = SERIAL[23:16];
            REG_SERIAL_1: reg_byte_s = SERIAL[15:8];
            REG_SERIAL_0: reg_byte_s = SERIAL[7:0];
`ifdef Z3_AUTOBOOT_EN
            REG_DIAG_HI:  reg_byte_s = DIAG_VEC[15:8];
            REG_DIAG_LO:  reg_byte_s = DIAG_VEC[7:0];
`endif
            default:      reg_byte_s = 8'h00;
        endcase
    end

    // er_Type is presented true, everything else inverted on the bus
    always_comb begin
        if (byte_off_s == REG_ER_TYPE) begin
            nibble = raw_s;
        end else begin
            nibble = ~raw_s;
        end
    end

endmodule

// File: rtl/z3_autoconfig.sv
// Zorro III autoconfig responder: decodes config cycles at 0xFFxxxxxx while
// the chain input is active, serves the config ROM nibbles, accepts the
// base-address and shut-up writes, then decodes its 16 MB BAR.
// Build option: Z3_AUTOBOOT_EN (see z3_cfg_rom).
module z3_autoconfig
    import z3_autoconfig_pkg::*;
#(
    parameter logic [15:0] MANUF_ID   = 16'h0202,
    parameter logic [7:0]  PRODUCT_ID = 8'h54,
    parameter logic [31:0] SERIAL     = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         RESET_n,
    input  logic [31:2]  ADDR,
    input  logic         READ,
    input  logic         FCS_n,
    input  logic         CFGIN_n,
    input  logic [31:24] DIN,
    output logic [31:28] DOUT,
    output logic         DOE,
    output logic         cfg_dtack,
    output logic         configured,
    output logic         slave_cycle,
    output logic         CFGOUT_n
);

    z3_state_e  state_r;
    z3_state_e  state_nxt_s;
    logic       dtack_r;
    logic       doe_r;
    logic [3:0] dout_r;
    logic [7:0] base_r;
    logic       configured_r;
    logic       shutup_r;
    logic       cfgout_n_r;

    logic       cfg_sel_s;
    logic [5:0] offset_s;
    logic [6:0] byte_off_s;
    logic [3:0] rom_nibble_s;
    logic       wr_base_s;
    logic       wr_shutup_s;
    logic       unused_addr_s;

    // Only the top byte and the register/nibble select bits take part in decode
    assign unused_addr_s = ^{ADDR[23:9], ADDR[7]};

    assign offset_s   = {ADDR[8], ADDR[6:2]};
    assign byte_off_s = {ADDR[6:2], 2'b00};
    assign cfg_sel_s  = ~CFGIN_n & ~configured_r & ~shutup_r & (ADDR[31:24] == 8'hFF);

    z3_cfg_rom #(
        .MANUF_ID   (MANUF_ID),
        .PRODUCT_ID (PRODUCT_ID),
        .SERIAL     (SERIAL)
    ) u_cfg_rom (
        .offset (offset_s),
        .nibble (rom_nibble_s)
    );

    // Write strobes, only valid on the acknowledging edge of a write cycle
    always_comb begin
        wr_base_s   = 1'b0;
        wr_shutup_s = 1'b0;
        if ((state_r == ST_ACK) && !READ) begin
            wr_base_s   = (byte_off_s == REG_BASE_ADDR);
            wr_shutup_s = (byte_off_s == REG_SHUTUP);
        end else begin
            wr_base_s   = 1'b0;
            wr_shutup_s = 1'b0;
        end
    end

    // Handshake state register
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Handshake next-state: ACK always moves on so a short strobe still ends cleanly
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_sel_s && !FCS_n) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACK: begin
                state_nxt_s = ST_WAIT_END;
            end
            ST_WAIT_END: begin
                if (FCS_n) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_END;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bus-side outputs: ack and read data rise in ACK, drop when the strobe ends
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            dtack_r <= 1'b0;
            doe_r   <= 1'b0;
            dout_r  <= 4'hF;
        end else begin
            case (state_r)
                ST_ACK: begin
                    dtack_r <= 1'b1;
                    if (READ) begin
                        dout_r <= rom_nibble_s;
                        doe_r  <= 1'b1;
                    end
                end
                ST_WAIT_END: begin
                    if (FCS_n) begin
                        dtack_r <= 1'b0;
                        doe_r   <= 1'b0;
                    end
                end
                default: begin
                    dtack_r <= 1'b0;
                    doe_r   <= 1'b0;
                end
            endcase
        end
    end

    // Configuration state: base latch, configured and shut-up flags
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            base_r       <= 8'h00;
            configured_r <= 1'b0;
            shutup_r     <= 1'b0;
        end else begin
            if (wr_base_s) begin
                base_r       <= DIN[31:24];
                configured_r <= 1'b1;
            end
            if (wr_shutup_s) begin
                shutup_r <= 1'b1;
            end
        end
    end

    // Pass the chain on only once the finishing cycle has fully returned to IDLE
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            cfgout_n_r <= 1'b1;
        end else begin
            cfgout_n_r <= ~((configured_r | shutup_r) & (state_r == ST_IDLE));
        end
    end

    assign cfg_dtack   = dtack_r;
    assign DOE         = doe_r;
    assign DOUT        = dout_r;
    assign configured  = configured_r;
    assign CFGOUT_n    = cfgout_n_r;
    assign slave_cycle = configured_r & (ADDR[31:24] == base_r) & ~FCS_n;

endmodule

// File: tb/tb_z3_autoconfig.sv
// Bench for z3_autoconfig: table of config-ROM reads, randomized config
// cycles against a register-image model, and hand sequences for the
// strobe-abort, base write, shut-up and mid-cycle reset cases.
module tb_z3_autoconfig;

    localparam logic [15:0] P_MANUF   = 16'h0202;
    localparam logic [7:0]  P_PRODUCT = 8'h54;
    localparam logic [31:0] P_SERIAL  = 32'h0000_0000;

    logic         CLK = 1'b0;
    logic         RESET_n;
    logic [31:2]  ADDR;
    logic         READ;
    logic         FCS_n;
    logic         CFGIN_n;
    logic [31:24] DIN;
    logic [31:28] DOUT;
    logic         DOE;
    logic         cfg_dtack;
    logic         configured;
    logic         slave_cycle;
    logic         CFGOUT_n;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic       m_conf;
    logic       m_shut;
    logic [7:0] m_base;

    z3_autoconfig #(
        .MANUF_ID   (P_MANUF),
        .PRODUCT_ID (P_PRODUCT),
        .SERIAL     (P_SERIAL)
    ) dut (
        .CLK         (CLK),
        .RESET_n     (RESET_n),
        .ADDR        (ADDR),
        .READ        (READ),
        .FCS_n       (FCS_n),
        .CFGIN_n     (CFGIN_n),
        .DIN         (DIN),
        .DOUT        (DOUT),
        .DOE         (DOE),
        .cfg_dtack   (cfg_dtack),
        .configured  (configured),
        .slave_cycle (slave_cycle),
        .CFGOUT_n    (CFGOUT_n)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // True register byte at register index idx (byte offset idx*4)
    function automatic logic [7:0] model_byte(input int idx);
        logic [7:0] er_type;
        logic [15:0] diag;
`ifdef Z3_AUTOBOOT_EN
        er_type = 8'h90;
        diag    = 16'h0200;
`else
        er_type = 8'h80;
        diag    = 16'h0000;
`endif
        if (idx == 0) return er_type;
        if (idx == 1) return P_PRODUCT;
        if (idx == 2) return 8'h30;
        if (idx == 4 || idx == 5) return 8'((P_MANUF >> (8 * (5 - idx))) & 16'h00FF);
        if (idx >= 6 && idx <= 9) return 8'((P_SERIAL >> (8 * (9 - idx))) & 32'hFF);
        if (idx == 10 || idx == 11) return 8'((diag >> (8 * (11 - idx))) & 16'h00FF);
        return 8'h00;
    endfunction

    function automatic logic [3:0] model_nibble(input logic [31:0] a);
        int idx;
        logic [7:0] b;
        logic [3:0] n;
        idx = int'(a[6:2]);
        b = model_byte(idx);
        n = a[8] ? b[3:0] : b[7:4];
        return (idx == 0) ? n : ~n;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RESET_n = 1'b0;
        FCS_n   = 1'b1;
        #1;
        chk("rst_dtack", 32'(cfg_dtack), 32'd0);
        chk("rst_doe", 32'(DOE), 32'd0);
        chk("rst_dout", 32'(DOUT), 32'hF);
        chk("rst_configured", 32'(configured), 32'd0);
        chk("rst_cfgout", 32'(CFGOUT_n), 32'd1);
        m_conf = 1'b0;
        m_shut = 1'b0;
        m_base = 8'h00;
        @(negedge CLK);
        RESET_n = 1'b1;
    endtask

    // One full cycle: strobe low for four edges, then released
    task automatic z3_cycle(input logic [31:0] a, input logic rd, input logic [7:0] d);
        logic exp_ack;
        logic prev_cfgout;
        exp_ack     = !CFGIN_n && !m_conf && !m_shut && (a[31:24] == 8'hFF);
        prev_cfgout = !(m_conf || m_shut);
        @(negedge CLK);
        ADDR  = a[31:2];
        READ  = rd;
        DIN   = d;
        FCS_n = 1'b0;
        @(negedge CLK);
        chk("dtack_edge1", 32'(cfg_dtack), 32'd0);
        @(negedge CLK);
        chk("dtack_edge2", 32'(cfg_dtack), 32'(exp_ack));
        chk("doe_edge2", 32'(DOE), 32'(exp_ack && rd));
        if (exp_ack && rd) chk("dout", 32'(DOUT), 32'(model_nibble(a)));
        if (exp_ack && !rd) begin
            if (a[6:2] == 5'h11) begin
                m_base = d;
                m_conf = 1'b1;
            end else if (a[6:2] == 5'h13) begin
                m_shut = 1'b1;
            end
        end
        chk("configured", 32'(configured), 32'(m_conf));
        @(negedge CLK);
        @(negedge CLK);
        chk("dtack_hold", 32'(cfg_dtack), 32'(exp_ack));
        FCS_n = 1'b1;
        @(negedge CLK);
        chk("dtack_end", 32'(cfg_dtack), 32'd0);
        chk("doe_end", 32'(DOE), 32'd0);
        chk("cfgout_exit", 32'(CFGOUT_n), 32'(prev_cfgout));
        @(negedge CLK);
        chk("cfgout_after", 32'(CFGOUT_n), 32'(!(m_conf || m_shut)));
    endtask

    task automatic slave_probe(input logic [31:0] a);
        @(negedge CLK);
        ADDR  = a[31:2];
        FCS_n = 1'b0;
        #1;
        chk("slave_cycle", 32'(slave_cycle), 32'(m_conf && (a[31:24] == m_base)));
        FCS_n = 1'b1;
        #1;
        chk("slave_idle", 32'(slave_cycle), 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  exp_dout;
    } rd_vec_t;

    rd_vec_t tbl[14];

    initial begin
        logic [31:0] a;
        int kind;
        int idx;

`ifdef Z3_AUTOBOOT_EN
        tbl[0]  = '{32'hFF00_0000, 4'h9};
        tbl[13] = '{32'hFF00_0128, 4'hD};
`else
        tbl[0]  = '{32'hFF00_0000, 4'h8};
        tbl[13] = '{32'hFF00_0128, 4'hF};
`endif
        tbl[1]  = '{32'hFF00_0100, 4'h0};
        tbl[2]  = '{32'hFF00_0004, 4'hA};
        tbl[3]  = '{32'hFF00_0104, 4'hB};
        tbl[4]  = '{32'hFF00_0008, 4'hC};
        tbl[5]  = '{32'hFF00_0108, 4'hF};
        tbl[6]  = '{32'hFF00_0010, 4'hF};
        tbl[7]  = '{32'hFF00_0110, 4'hD};
        tbl[8]  = '{32'hFF00_0014, 4'hF};
        tbl[9]  = '{32'hFF00_0114, 4'hD};
        tbl[10] = '{32'hFF00_0018, 4'hF};
        tbl[11] = '{32'hFF00_0028, 4'hF};
        tbl[12] = '{32'hFF00_0040, 4'hF};

        RESET_n = 1'b0;
        ADDR    = 30'h0;
        READ    = 1'b1;
        FCS_n   = 1'b1;
        CFGIN_n = 1'b0;
        DIN     = 8'h00;
        m_conf  = 1'b0;
        m_shut  = 1'b0;
        m_base  = 8'h00;
        repeat (2) @(negedge CLK);
        do_reset();

        // Table of ROM reads
        for (int i = 0; i < 14; i++) begin
            z3_cycle(tbl[i].addr, 1'b1, 8'h00);
            chk("table_dout", 32'(DOUT), 32'(tbl[i].exp_dout));
        end

        // Randomized reads, foreign addresses, inert writes, chain inactive
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 3));
            a = $urandom;
            a[1:0] = 2'b00;
            a[31:24] = 8'hFF;
            CFGIN_n = ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0;
            if (kind == 0 || kind == 3) begin
                z3_cycle(a, 1'b1, 8'h00);
            end else if (kind == 1) begin
                a[31:24] = 8'($urandom_range(0, 254));
                z3_cycle(a, 1'b1, 8'h00);
            end else begin
                idx = int'($urandom_range(0, 31));
                if (idx == 17 || idx == 19) idx = 18;
                a[6:2] = 5'(idx);
                z3_cycle(a, 1'b0, 8'($urandom));
            end
        end
        CFGIN_n = 1'b0;

        // Chain input inactive: no response
        CFGIN_n = 1'b1;
        z3_cycle(32'hFF00_0000, 1'b1, 8'h00);
        CFGIN_n = 1'b0;

        // Strobe released while in ACK: one acked edge, then back to IDLE
        @(negedge CLK);
        ADDR  = 30'h3FC0_0000;
        READ  = 1'b1;
        FCS_n = 1'b0;
        @(negedge CLK);
        FCS_n = 1'b1;
        chk("abort_ack_edge1", 32'(cfg_dtack), 32'd0);
        @(negedge CLK);
        chk("abort_dtack", 32'(cfg_dtack), 32'd1);
        chk("abort_doe", 32'(DOE), 32'd1);
        chk("abort_dout", 32'(DOUT), 32'(model_nibble(32'hFF00_0000)));
        @(negedge CLK);
        chk("abort_dtack_end", 32'(cfg_dtack), 32'd0);
        chk("abort_doe_end", 32'(DOE), 32'd0);

        // Reset while in WAIT_END of a base write
        @(negedge CLK);
        ADDR  = 30'h3FC0_0011;
        READ  = 1'b0;
        DIN   = 8'h40;
        FCS_n = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("midrst_configured_pre", 32'(configured), 32'd1);
        do_reset();
        chk("midrst_configured_post", 32'(configured), 32'd0);
        chk("midrst_cfgout_post", 32'(CFGOUT_n), 32'd1);
        z3_cycle(32'hFF00_0000, 1'b1, 8'h00);

        // Base write, BAR decode, no further config response
        z3_cycle(32'hFF00_0044, 1'b0, 8'h40);
        chk("base_cfgout", 32'(CFGOUT_n), 32'd0);
        slave_probe(32'h4012_3400);
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            if (i % 3 == 0) a[31:24] = 8'h40;
            slave_probe(a);
        end
        z3_cycle(32'hFF00_0000, 1'b1, 8'h00);
        slave_probe(32'h4000_0000);

        // Shut-up: chain passes on without configuring, BAR never decodes
        do_reset();
        z3_cycle(32'hFF00_004C, 1'b0, 8'h40);
        chk("shutup_configured", 32'(configured), 32'd0);
        chk("shutup_cfgout", 32'(CFGOUT_n), 32'd0);
        slave_probe(32'h0000_0000);
        slave_probe(32'h4012_3400);
        slave_probe(32'h00AB_CD00);
        z3_cycle(32'hFF00_0044, 1'b0, 8'h40);
        chk("shutup_no_config", 32'(configured), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
